nx_node_router: RTL and testbench

- Parametrised crossbar router that replaces the fixed inbound arbiter, bypass combiner and outbound distributor chain inside a node.
- Accepts NUM_PORTS inbound message streams: the mesh directions plus one local-inject port fed by the node control emitter.
- Routes each message by dimension-ordered XY to one of NUM_PORTS outbound streams: the mesh directions plus one local-deliver port feeding the message decoder.
- Each output is buffered by its own FIFO. Each output has its own arbiter, configurable as round-robin or fixed priority. Messages routed towards an absent neighbour are counted and discarded.

---
 rtl/nx_node_router_pkg.sv | 40 ++++
 rtl/nx_router_fifo.sv | 50 +++++
 rtl/nx_node_router.sv | 150 +++++++++++++++
 tb/tb_nx_node_router.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_node_router_pkg.sv
// Shared constants and types for the node router.
// Holds the message format, port directions, arbitration names and XY routing.
package nx_node_router_pkg;

    localparam int ADDR_ROW_WIDTH = 4;
    localparam int ADDR_COL_WIDTH = 4;
    localparam int PAYLOAD_WIDTH  = 24;

    typedef struct packed {
        logic [ADDR_ROW_WIDTH-1:0] tgt_row;
        logic [ADDR_COL_WIDTH-1:0] tgt_col;
        logic [PAYLOAD_WIDTH-1:0]  payload;
    } node_message_t;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } direction_t;

    localparam string ARB_ROUND_ROBIN = "round_robin";
    localparam string ARB_FIXED       = "fixed";

    // Dimension-ordered: resolve the column first, then the row.
    function automatic direction_t route_xy(
        input logic [ADDR_ROW_WIDTH-1:0] tgt_row,
        input logic [ADDR_COL_WIDTH-1:0] tgt_col,
        input logic [ADDR_ROW_WIDTH-1:0] node_row,
        input logic [ADDR_COL_WIDTH-1:0] node_col
    );
        if (tgt_row == node_row && tgt_col == node_col) return LOCAL;
        if (tgt_col > node_col) return EAST;
        if (tgt_col < node_col) return WEST;
        if (tgt_row > node_row) return SOUTH;
        return NORTH;
    endfunction

endpackage

// File: rtl/nx_router_fifo.sv
// Single-clock output FIFO with a register-file head.
// Ports: clk_i, rst_i, push_i/data_i, pop_i, full_o, empty_o, head_o.
module nx_router_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // The extra top bit tells full apart from empty when indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO refuses a write even if it is popped in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/nx_node_router.sv
// Node crossbar: XY route, per-output arbitration and FIFO, drop counting.
// Ports: clk/rst, node address, inbound/outbound streams, presence, idle, drops.
module nx_node_router
    import nx_node_router_pkg::*;
#(
    parameter int    NUM_PORTS      = 5,
    parameter int    FIFO_DEPTH     = 2,
    parameter string ARB_SCHEME     = "round_robin",
    parameter int    DROP_CNT_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0]     node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0]     node_col_i,
    output logic                          idle_o,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count_o,
    input  node_message_t [NUM_PORTS-1:0] ib_data_i,
    input  logic [NUM_PORTS-1:0]          ib_valid_i,
    output logic [NUM_PORTS-1:0]          ib_ready_o,
    output node_message_t [NUM_PORTS-1:0] ob_data_o,
    output logic [NUM_PORTS-1:0]          ob_valid_o,
    input  logic [NUM_PORTS-1:0]          ob_ready_i,
    input  logic [NUM_PORTS-1:0]          ob_present_i
);

    localparam int PW  = $clog2(NUM_PORTS);
    localparam int LOC = NUM_PORTS - 1;
    localparam bit FIXED_MODE = (ARB_SCHEME == ARB_FIXED);

    if (NUM_PORTS != 5) begin : g_bad_ports
        $error("nx_node_router: NUM_PORTS must be 5");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("nx_node_router: FIFO_DEPTH must be a power of two >= 2");
    end
    if (ARB_SCHEME != ARB_ROUND_ROBIN && ARB_SCHEME != ARB_FIXED) begin : g_bad_arb
        $error("nx_node_router: unknown ARB_SCHEME");
    end

    direction_t           dir [NUM_PORTS];
    logic [NUM_PORTS-1:0] drop;
    logic [NUM_PORTS-1:0] present;
    logic [NUM_PORTS-1:0] gnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] granted;
    logic [NUM_PORTS-1:0] full, empty;

    // The local deliver port always exists.
    assign present = ob_present_i | (NUM_PORTS'(1) << LOC);

    for (genvar s = 0; s < NUM_PORTS; s++) begin : g_src
        assign dir[s] = route_xy(ib_data_i[s].tgt_row, ib_data_i[s].tgt_col,
                                 node_row_i, node_col_i);
        // Absent neighbour, or a mesh source routed back where it came from.
        assign drop[s] = ib_valid_i[s] &&
                         (!present[dir[s]] || (s != LOC && int'(dir[s]) == s));
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0] req_l, gnt_l;
        logic [PW-1:0]        idx_l, cand, ptr_q, ptr_d;
        logic [PW:0]          sum;

        // Scan from the pointer downwards so the nearest requester wins.
        always_comb begin
            req_l = '0;
            gnt_l = '0;
            idx_l = '0;
            sum   = '0;
            cand  = '0;
            for (int s = 0; s < NUM_PORTS; s++)
                req_l[s] = ib_valid_i[s] && !drop[s] && (int'(dir[s]) == o);
            if (!full[o]) begin
                for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                    sum = {1'b0, ptr_q} + (PW+1)'(k);
                    if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
                    cand = sum[PW-1:0];
                    if (req_l[cand]) begin
                        gnt_l = '0;
                        gnt_l[cand] = 1'b1;
                        idx_l = cand;
                    end
                end
            end
        end

        assign ptr_d = !(|gnt_l) ? ptr_q :
                       (idx_l == PW'(NUM_PORTS - 1)) ? '0 : idx_l + 1'b1;

        if (FIXED_MODE) begin : g_fixed
            assign ptr_q = '0;
        end else begin : g_rr
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) ptr_q <= '0;
                else       ptr_q <= ptr_d;
            end
        end

        assign gnt[o] = gnt_l;

        nx_router_fifo #(
            .WIDTH ($bits(node_message_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (|gnt_l),
            .data_i  (ib_data_i[idx_l]),
            .pop_i   (ob_ready_i[o]),
            .full_o  (full[o]),
            .empty_o (empty[o]),
            .head_o  (ob_data_o[o])
        );

        assign ob_valid_o[o] = !empty[o];
    end

    always_comb begin
        granted = '0;
        for (int o = 0; o < NUM_PORTS; o++) granted = granted | gnt[o];
    end

    assign ib_ready_o = granted | drop;

    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_WIDTH:0]   cnt_sum;
    logic                      idle_q, idle_d;

    always_comb begin
        cnt_sum = {1'b0, drop_cnt_q};
        for (int s = 0; s < NUM_PORTS; s++)
            cnt_sum = cnt_sum + {{DROP_CNT_WIDTH{1'b0}}, drop[s]};
        drop_cnt_d = cnt_sum[DROP_CNT_WIDTH] ? '1 : cnt_sum[DROP_CNT_WIDTH-1:0];
    end

    assign idle_d = (&empty) && !(|ib_valid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
            idle_q     <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
    assign idle_o       = idle_q;

endmodule

// File: tb/tb_nx_node_router.sv
// Directed bench for nx_node_router at node (2,2).
// Round-robin and fixed-priority instances share stimulus.
module tb_nx_node_router;
    import nx_node_router_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          node_row, node_col;
    node_message_t [4:0] ib_data;
    logic [4:0]          ib_valid, ob_ready, ob_present;

    logic                idle, idle_fx;
    logic [15:0]         drop_cnt, drop_fx;
    logic [4:0]          ib_ready, ib_ready_fx;
    node_message_t [4:0] ob_data, ob_data_fx;
    logic [4:0]          ob_valid, ob_valid_fx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nx_node_router #(.ARB_SCHEME("round_robin")) dut (
        .clk_i(clk), .rst_i(rst), .node_row_i(node_row), .node_col_i(node_col),
        .idle_o(idle), .drop_count_o(drop_cnt),
        .ib_data_i(ib_data), .ib_valid_i(ib_valid), .ib_ready_o(ib_ready),
        .ob_data_o(ob_data), .ob_valid_o(ob_valid), .ob_ready_i(ob_ready),
        .ob_present_i(ob_present)
    );

    nx_node_router #(.ARB_SCHEME("fixed")) dut_fx (
        .clk_i(clk), .rst_i(rst), .node_row_i(node_row), .node_col_i(node_col),
        .idle_o(idle_fx), .drop_count_o(drop_fx),
        .ib_data_i(ib_data), .ib_valid_i(ib_valid), .ib_ready_o(ib_ready_fx),
        .ob_data_o(ob_data_fx), .ob_valid_o(ob_valid_fx), .ob_ready_i(ob_ready),
        .ob_present_i(ob_present)
    );

    function automatic node_message_t msg(input logic [3:0] r, input logic [3:0] c,
                                          input logic [23:0] p);
        node_message_t m;
        m.tgt_row = r;
        m.tgt_col = c;
        m.payload = p;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ib_valid = '0;
        ib_data = '0;
        ob_ready = '1;
        ob_present = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ib_valid = '0;
        ib_data = '0;
        ob_ready = '1;
        ob_present = '1;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (ob_valid !== 5'b0) begin
            errors++; $display("FAIL reset_ob_valid: got %b expected %b", ob_valid, 5'b0);
        end
        checks++;
        if (ob_data !== '0) begin
            errors++; $display("FAIL reset_ob_data: got %h expected 0", ob_data);
        end
        checks++;
        if (drop_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_drop: got %h expected 0", drop_cnt);
        end
        checks++;
        if (idle !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got %b expected 0", idle);
        end
        checks++;
        if (ib_ready !== 5'b0) begin
            errors++; $display("FAIL reset_ib_ready: got %b expected 0", ib_ready);
        end
    endtask

    task automatic test_route();
        logic [3:0]    rows [6] = '{4'd2, 4'd2, 4'd5, 4'd0, 4'd2, 4'd7};
        logic [3:0]    cols [6] = '{4'd5, 4'd0, 4'd2, 4'd2, 4'd2, 4'd15};
        int            exps [6] = '{1, 3, 2, 0, 4, 1};
        node_message_t m;
        logic [4:0]    onehot;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            m = msg(rows[i], cols[i], 24'h100 + 24'(i));
            onehot = 5'b00001 << exps[i];
            ib_data[4] = m;
            ib_valid = 5'b10000;
            #1;
            checks++;
            if (ib_ready !== 5'b10000) begin
                errors++; $display("FAIL route%0d_ready: got %b expected %b", i, ib_ready, 5'b10000);
            end
            tick();
            ib_valid = '0;
            checks++;
            if (ob_valid !== onehot) begin
                errors++; $display("FAIL route%0d_valid: got %b expected %b", i, ob_valid, onehot);
            end
            checks++;
            if (ob_data[exps[i]] !== m) begin
                errors++; $display("FAIL route%0d_data: got %h expected %h", i, ob_data[exps[i]], m);
            end
            tick();
        end
        checks++;
        if (drop_cnt !== 16'h0) begin
            errors++; $display("FAIL route_drop: got %h expected 0", drop_cnt);
        end
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL route_idle: got %b expected 1", idle);
        end
    endtask

    task automatic test_arbitration();
        node_message_t a0, a2, want;
        logic [4:0]    exp_rr;
        a0 = msg(4'd2, 4'd2, 24'hA0);
        a2 = msg(4'd2, 4'd2, 24'hA2);
        do_reset();
        ib_data[0] = a0;
        ib_data[2] = a2;
        ib_valid = 5'b00101;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_rr = (i % 2 == 0) ? 5'b00001 : 5'b00100;
            checks++;
            if (ib_ready !== exp_rr) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, ib_ready, exp_rr);
            end
            checks++;
            if (ib_ready_fx !== 5'b00001) begin
                errors++; $display("FAIL fixed_grant%0d: got %b expected %b", i, ib_ready_fx, 5'b00001);
            end
            if (i > 0) begin
                want = ((i - 1) % 2 == 0) ? a0 : a2;
                checks++;
                if (ob_data[4] !== want) begin
                    errors++; $display("FAIL rr_order%0d: got %h expected %h", i, ob_data[4], want);
                end
            end
            tick();
        end
        ib_valid = 5'b00100;
        #1;
        checks++;
        if (ib_ready_fx !== 5'b00100) begin
            errors++; $display("FAIL fixed_release: got %b expected %b", ib_ready_fx, 5'b00100);
        end
        tick();
        ib_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        node_message_t m [3];
        for (int i = 0; i < 3; i++) m[i] = msg(4'd2, 4'd5, 24'h30 + 24'(i));
        do_reset();
        ob_ready[1] = 1'b0;
        ib_data[3] = m[0];
        ib_valid = 5'b01000;
        #1;
        checks++;
        if (ib_ready[3] !== 1'b1) begin
            errors++; $display("FAIL bp_accept0: got %b expected 1", ib_ready[3]);
        end
        tick();
        ib_data[3] = m[1];
        #1;
        checks++;
        if (ib_ready[3] !== 1'b1) begin
            errors++; $display("FAIL bp_accept1: got %b expected 1", ib_ready[3]);
        end
        tick();
        ib_data[3] = m[2];
        #1;
        checks++;
        if (ib_ready[3] !== 1'b0) begin
            errors++; $display("FAIL bp_full: got %b expected 0", ib_ready[3]);
        end
        tick();
        checks++;
        if (ob_data[1] !== m[0] || ob_valid[1] !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got %h/%b expected %h/1", ob_data[1], ob_valid[1], m[0]);
        end
        ob_ready[1] = 1'b1;
        #1;
        checks++;
        if (ib_ready[3] !== 1'b0) begin
            errors++; $display("FAIL bp_full_pop: got %b expected 0", ib_ready[3]);
        end
        tick();
        ob_ready[1] = 1'b0;
        #1;
        checks++;
        if (ib_ready[3] !== 1'b1) begin
            errors++; $display("FAIL bp_reopen: got %b expected 1", ib_ready[3]);
        end
        checks++;
        if (ob_data[1] !== m[1]) begin
            errors++; $display("FAIL bp_head1: got %h expected %h", ob_data[1], m[1]);
        end
        tick();
        ib_valid = '0;
        ob_ready[1] = 1'b1;
        tick();
        checks++;
        if (ob_data[1] !== m[2] || ob_valid[1] !== 1'b1) begin
            errors++; $display("FAIL bp_head2: got %h/%b expected %h/1", ob_data[1], ob_valid[1], m[2]);
        end
        tick();
        checks++;
        if (ob_valid[1] !== 1'b0) begin
            errors++; $display("FAIL bp_drained: got %b expected 0", ob_valid[1]);
        end
    endtask

    task automatic test_drop();
        do_reset();
        ob_present = 5'b11110;
        ib_data[1] = msg(4'd0, 4'd2, 24'hD1);
        ib_data[4] = msg(4'd0, 4'd2, 24'hD4);
        ib_valid = 5'b10010;
        #1;
        checks++;
        if (ib_ready !== 5'b10010) begin
            errors++; $display("FAIL drop_ready: got %b expected %b", ib_ready, 5'b10010);
        end
        tick();
        ib_valid = '0;
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++; $display("FAIL drop_count2: got %0d expected 2", drop_cnt);
        end
        checks++;
        if (ob_valid !== 5'b0) begin
            errors++; $display("FAIL drop_no_out: got %b expected 0", ob_valid);
        end
        ob_present = '1;
        ib_data[2] = msg(4'd5, 4'd2, 24'hD2);
        ib_valid = 5'b00100;
        #1;
        checks++;
        if (ib_ready !== 5'b00100) begin
            errors++; $display("FAIL uturn_ready: got %b expected %b", ib_ready, 5'b00100);
        end
        tick();
        ib_valid = '0;
        checks++;
        if (drop_cnt !== 16'd3 || ob_valid !== 5'b0) begin
            errors++; $display("FAIL uturn_drop: got %0d/%b expected 3/00000", drop_cnt, ob_valid);
        end
        ob_present = 5'b11110;
        for (int s = 0; s < 5; s++) ib_data[s] = msg(4'd0, 4'd2, 24'(s));
        ib_valid = 5'b11111;
        #1;
        checks++;
        if (ib_ready !== 5'b11111) begin
            errors++; $display("FAIL drop_all_ready: got %b expected %b", ib_ready, 5'b11111);
        end
        tick();
        checks++;
        if (drop_cnt !== 16'd8) begin
            errors++; $display("FAIL drop_count8: got %0d expected 8", drop_cnt);
        end
        repeat (13106) tick();
        ib_valid = '0;
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL drop_sat: got %h expected ffff", drop_cnt);
        end
        ib_valid = 5'b10010;
        tick();
        ib_valid = '0;
        checks++;
        if (drop_cnt !== 16'hFFFF || ob_valid !== 5'b0) begin
            errors++; $display("FAIL drop_sat_hold: got %h/%b expected ffff/00000", drop_cnt, ob_valid);
        end
        ob_present = '1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ob_ready[2] = 1'b0;
        ib_data[4] = msg(4'd5, 4'd2, 24'h55);
        ib_valid = 5'b10000;
        tick();
        ib_valid = '0;
        ib_data = '0;
        checks++;
        if (ob_valid !== 5'b00100) begin
            errors++; $display("FAIL mid_buffered: got %b expected %b", ob_valid, 5'b00100);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ob_valid !== 5'b0 || ob_data[2] !== '0) begin
            errors++; $display("FAIL mid_async: got %b/%h expected 00000/0", ob_valid, ob_data[2]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (idle !== 1'b0) begin
            errors++; $display("FAIL mid_idle_release: got %b expected 0", idle);
        end
        tick();
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL mid_idle: got %b expected 1", idle);
        end
        ob_ready = '1;
    endtask

    initial begin
        node_row = 4'd2;
        node_col = 4'd2;
        test_reset();
        test_route();
        test_arbitration();
        test_backpressure();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
